// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter_if
// Description : Requester-side and data-memory-side signal bundle for
//               dmem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    // requester 0 (CPU load/store unit)
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [31:0]       wdata0;
    logic [3:0]        mask0;
    logic              gnt0;
    logic              done0;
    logic [31:0]       rdata0;
    // requester 1 (debug/DMA loader)
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [31:0]       wdata1;
    logic [3:0]        mask1;
    logic              gnt1;
    logic              done1;
    logic [31:0]       rdata1;
    // data memory
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_sign_mask;
    logic              mem_memread;
    logic              mem_memwrite;
    logic [31:0]       mem_rdata;
    logic              mem_stall;

    modport slave (
        input  req0, we0, addr0, wdata0, mask0,
        input  req1, we1, addr1, wdata1, mask1,
        output gnt0, done0, rdata0,
        output gnt1, done1, rdata1,
        output mem_addr, mem_wdata, mem_sign_mask, mem_memread, mem_memwrite,
        input  mem_rdata, mem_stall
    );

    modport master (
        output req0, we0, addr0, wdata0, mask0,
        output req1, we1, addr1, wdata1, mask1,
        input  gnt0, done0, rdata0,
        input  gnt1, done1, rdata1,
        input  mem_addr, mem_wdata, mem_sign_mask, mem_memread, mem_memwrite,
        output mem_rdata, mem_stall
    );
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Two-port arbiter in front of a single-port data memory; one
//               access in flight, sequenced IDLE -> ISSUE -> WAIT -> DONE.
//               Optional macro DMEM_ARB_FIXED_PRIO_EN: port 0 always wins.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int READ_LAT = 1,
    parameter int ADDR_W   = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    dmem_port_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] C_LAT_INIT = 3'(READ_LAT - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_owner;
    logic              w_sel_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_mask;
    logic [2:0]        r_cnt;
    logic [31:0]       r_rdata0;
    logic [31:0]       r_rdata1;
    logic              w_any_req;
    logic              w_wait_exit;

    assign w_any_req   = bus.req0 | bus.req1;
    assign w_wait_exit = (r_state == S_WAIT) && (r_cnt == 3'd0) && !bus.mem_stall;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Port 1 only wins when port 0 is not requesting.
    always_comb begin
        w_sel_owner = ~bus.req0;
    end
`else
    logic r_last_owner;

    always_comb begin
        w_sel_owner = bus.req1;
        if (bus.req0 && bus.req1) begin
            w_sel_owner = ~r_last_owner;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_owner <= 1'b1;
        end else if (r_state == S_DONE) begin
            r_last_owner <= r_owner;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  if (w_wait_exit) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request capture and latency counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_mask  <= 4'd0;
            r_cnt   <= 3'd0;
        end else begin
            if ((r_state == S_IDLE) && w_any_req) begin
                r_owner <= w_sel_owner;
                r_we    <= w_sel_owner ? bus.we1    : bus.we0;
                r_addr  <= w_sel_owner ? bus.addr1  : bus.addr0;
                r_wdata <= w_sel_owner ? bus.wdata1 : bus.wdata0;
                r_mask  <= w_sel_owner ? bus.mask1  : bus.mask0;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= C_LAT_INIT;
            end else if ((r_state == S_WAIT) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    // Load data is sampled on the WAIT->DONE edge and held until the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata0 <= 32'd0;
            r_rdata1 <= 32'd0;
        end else if (w_wait_exit && !r_we) begin
            if (r_owner) begin
                r_rdata1 <= bus.mem_rdata;
            end else begin
                r_rdata0 <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        bus.gnt0         = 1'b0;
        bus.gnt1         = 1'b0;
        bus.done0        = 1'b0;
        bus.done1        = 1'b0;
        bus.mem_memread  = 1'b0;
        bus.mem_memwrite = 1'b0;
        case (r_state)
            S_ISSUE: begin
                bus.gnt0         = ~r_owner;
                bus.gnt1         = r_owner;
                bus.mem_memread  = ~r_we;
                bus.mem_memwrite = r_we;
            end
            S_DONE: begin
                bus.done0 = ~r_owner;
                bus.done1 = r_owner;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr      = r_addr;
    assign bus.mem_wdata     = r_wdata;
    assign bus.mem_sign_mask = r_mask;
    assign bus.rdata0        = r_rdata0;
    assign bus.rdata1        = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Directed self-checking bench for dmem_port_arbiter (READ_LAT=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    localparam int READ_LAT = 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    dmem_port_arbiter_if #(.ADDR_W(32)) bus ();

    dmem_port_arbiter #(
        .READ_LAT (READ_LAT),
        .ADDR_W   (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks at least once, then until a grant appears (bounded).
    task automatic wait_gnt(output int port, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!(bus.gnt0 || bus.gnt1) && cycles < 20);
        if (!(bus.gnt0 || bus.gnt1)) begin
            check("gnt_timeout", 32'(bus.gnt0 | bus.gnt1), 32'd1);
            port = -1;
        end else begin
            port = bus.gnt1 ? 1 : 0;
        end
    endtask

    initial begin
        int p;
        int c;
        int exp_order [3];
        logic [31:0] held_addr;
        logic        addr_moved;
        logic        extra_gnt;

`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0};
`else
        exp_order = '{0, 1, 0};
`endif
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0; bus.mask0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0; bus.mask1 = 0;
        bus.mem_rdata = 0; bus.mem_stall = 0;
        reset = 1;
        tick();
        tick();
        check("rst_strobes", {26'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                              bus.mem_memread, bus.mem_memwrite}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_rdata0", bus.rdata0, 32'd0);
        check("rst_rdata1", bus.rdata1, 32'd0);
        reset = 0;
        tick();

        // single load on port 0
        bus.mem_rdata = 32'hDEADBEEF;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h10; bus.mask0 = 4'b0111;
        wait_gnt(p, c);
        check("ld_gnt_port", 32'(p), 32'd0);
        check("ld_gnt_lat", 32'(c), 32'd1);
        check("ld_memread", 32'(bus.mem_memread), 32'd1);
        check("ld_memwrite", 32'(bus.mem_memwrite), 32'd0);
        check("ld_addr", bus.mem_addr, 32'h10);
        check("ld_mask", 32'(bus.mem_sign_mask), 32'd7);
        bus.req0 = 0;
        tick();
        check("ld_memread_off", 32'(bus.mem_memread), 32'd0);
        check("ld_addr_held", bus.mem_addr, 32'h10);
        tick();
        check("ld_done0", 32'(bus.done0), 32'd1);
        check("ld_rdata0", bus.rdata0, 32'hDEADBEEF);
        check("ld_rdata1", bus.rdata1, 32'd0);
        tick();
        check("ld_done0_off", 32'(bus.done0), 32'd0);
        check("ld_rdata0_hold", bus.rdata0, 32'hDEADBEEF);

        // store on port 1 to the LED address
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 32'h2000; bus.wdata1 = 32'hA5; bus.mask1 = 4'b0010;
        wait_gnt(p, c);
        check("st_gnt_port", 32'(p), 32'd1);
        check("st_memwrite", 32'(bus.mem_memwrite), 32'd1);
        check("st_memread", 32'(bus.mem_memread), 32'd0);
        check("st_addr", bus.mem_addr, 32'h2000);
        check("st_wdata", bus.mem_wdata, 32'hA5);
        check("st_mask", 32'(bus.mem_sign_mask), 32'd2);
        bus.req1 = 0;
        tick();
        check("st_memwrite_off", 32'(bus.mem_memwrite), 32'd0);
        tick();
        check("st_done1", 32'(bus.done1), 32'd1);
        check("st_done0", 32'(bus.done0), 32'd0);
        check("st_rdata1", bus.rdata1, 32'd0);
        tick();

        // simultaneous requests from reset
        reset = 1;
        tick();
        reset = 0;
        tick();
        bus.we0 = 0; bus.addr0 = 32'h100;
        bus.we1 = 0; bus.addr1 = 32'h200;
        bus.req0 = 1; bus.req1 = 1;
        for (int i = 0; i < 3; i++) begin
            wait_gnt(p, c);
            check($sformatf("rr_order%0d", i), 32'(p), 32'(exp_order[i]));
            check($sformatf("rr_gap%0d", i), 32'(c), (i == 0) ? 32'd1 : 32'(READ_LAT + 3));
            check($sformatf("rr_excl%0d", i), 32'(bus.gnt0 & bus.gnt1), 32'd0);
        end
        bus.req0 = 0; bus.req1 = 0;
        tick();
        tick();
        check("rr_done_excl", {30'd0, bus.done0, bus.done1}, (exp_order[2] == 0) ? 32'd2 : 32'd1);
        tick();

        // stall of 4 WAIT cycles; stall also high in ISSUE, where it is ignored
        bus.mem_rdata = 32'hCAFEF00D;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h40; bus.mask0 = 4'b1111;
        wait_gnt(p, c);
        check("stl_gnt", 32'(p), 32'd0);
        held_addr = bus.mem_addr;
        bus.req0 = 0;
        bus.mem_stall = 1;
        addr_moved = 0;
        extra_gnt  = 0;
        c = 0;
        do begin
            tick();
            c++;
            if (bus.mem_addr !== held_addr) addr_moved = 1;
            if (bus.gnt0 || bus.gnt1) extra_gnt = 1;
            if (c == 5) bus.mem_stall = 0;
        end while (!bus.done0 && c < 30);
        check("stl_done_delay", 32'(c), 32'(READ_LAT + 1 + 4));
        check("stl_addr_stable", 32'(addr_moved), 32'd0);
        check("stl_no_regnt", 32'(extra_gnt), 32'd0);
        check("stl_rdata0", bus.rdata0, 32'hCAFEF00D);
        tick();

        // reset asserted in WAIT of a port 1 load
        bus.mem_rdata = 32'h12345678;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h80; bus.mask1 = 4'b0101;
        wait_gnt(p, c);
        check("mid_gnt", 32'(p), 32'd1);
        bus.req1 = 0;
        tick();
        reset = 1;
        #1;
        check("mid_strobes", {26'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                              bus.mem_memread, bus.mem_memwrite}, 32'd0);
        check("mid_addr", bus.mem_addr, 32'd0);
        check("mid_wdata", bus.mem_wdata, 32'd0);
        check("mid_mask", 32'(bus.mem_sign_mask), 32'd0);
        check("mid_rdata0", bus.rdata0, 32'd0);
        check("mid_rdata1", bus.rdata1, 32'd0);
        tick();
        reset = 0;
        tick();
        check("mid_no_done", {30'd0, bus.done0, bus.done1}, 32'd0);
        tick();
        check("mid_no_done2", {30'd0, bus.done0, bus.done1}, 32'd0);
        bus.req0 = 1; bus.req1 = 1;
        wait_gnt(p, c);
        check("mid_rr_port0", 32'(p), 32'd0);
        bus.req0 = 0; bus.req1 = 0;
        tick();
        tick();
        tick();

        // early drop of req1 while port 0 waits
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h44;
        wait_gnt(p, c);
        check("ed_gnt0", 32'(p), 32'd0);
        bus.req0 = 0;
        tick();
        bus.req1 = 1;
        extra_gnt = 0;
        tick();
        bus.req1 = 0;
        check("ed_done0", 32'(bus.done0), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.gnt1) extra_gnt = 1;
        end
        check("ed_no_gnt1", 32'(extra_gnt), 32'd0);
        bus.req0 = 1;
        wait_gnt(p, c);
        check("ed_idle_regnt", 32'(c), 32'd1);
        bus.req0 = 0;
        tick();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the CPU load/store unit and port 1 is the debug/DMA loader.
- Only one access is in flight at a time. Each access is sequenced issue -> wait -> complete, and the memory stall is respected.
- Sits between the requesters and the data memory. It drives that memory's addr, write_data, memread, memwrite and sign_mask inputs, and consumes its read_data and clk_stall outputs.

Parameters:
- READ_LAT, 1, minimum cycles from issue to sampling mem_read_data (1..7).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  access request, held until gnt.
- we0 / we1  in  1  1 = store, 0 = load.
- addr0 / addr1  in  ADDR_W  byte address.
- wdata0 / wdata1  in  32  store data.
- mask0 / mask1  in  4  sign_mask encoding, passed through unchanged.
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, inputs captured.
- done0 / done1  out  1  one-cycle pulse: access complete.
- rdata0 / rdata1  out  32  load result, valid from the done cycle and held until that port's next load completes.
- mem_addr  out  ADDR_W  to memory.
- mem_wdata  out  32  to memory.
- mem_sign_mask  out  4  to memory.
- mem_memread  out  1  to memory.
- mem_memwrite  out  1  to memory.
- mem_rdata  in  32  from memory.
- mem_stall  in  1  memory busy (clk_stall).

Behaviour:
- Reset (async, any state):
  - state=IDLE, last_owner=1, wait counter=0.
  - All gnt/done/mem_* outputs 0; rdata0 and rdata1 = 0.
  - An in-flight access is abandoned with no done pulse.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req0|req1 is high at an edge, select the owner, register addr/wdata/mask/we from that port, and go to ISSUE.
  - Owner selection when both requests are high: the port that is not last_owner wins (round-robin). Otherwise the single requester wins.
- ISSUE (exactly 1 cycle):
  - gnt_owner=1.
  - mem_memread=~we or mem_memwrite=we; mem_addr/wdata/sign_mask driven from the registers.
  - Load counter with READ_LAT-1; go to WAIT.
- WAIT:
  - Strobes low; mem_addr/wdata/sign_mask held stable.
  - Decrement the counter toward 0.
  - Leave for DONE only when counter==0 and mem_stall==0. A stall holds WAIT indefinitely.
- DONE (1 cycle):
  - done_owner=1; last_owner<=owner.
  - On a load, rdata_owner<=mem_rdata, sampled at the WAIT->DONE edge.
  - Go to IDLE.
- Latency:
  - gnt is 1 cycle after req is sampled.
  - done is READ_LAT+1 cycles after gnt when there is no stall.
  - Minimum request-to-done is READ_LAT+2 cycles; back-to-back accesses are READ_LAT+3 cycles apart.
- Boundary conditions:
  - A request deasserted before gnt is ignored, with no error.
  - A request still high after done is re-arbitrated as a new access.
  - A loser's request stays pending; it is not lost.
  - Stores to 0x2000 (LED) pass through like any other store.
  - mem_stall seen in IDLE or ISSUE is ignored; only WAIT honours it.
  - gnt0&gnt1 and done0&done1 are never high together.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins a simultaneous request, and last_owner is unused. Port 1 can starve.
- Undefined (default): round-robin as specified above.

Test Plan:
- Single load:
  - Stimulus: reset; req0=1, we0=0, addr0=0x10, mask0=0b0111; memory returns 0xDEADBEEF.
  - Required: gnt0 at +1; mem_memread for 1 cycle; done0 at +3 (READ_LAT=1); rdata0=0xDEADBEEF; rdata1 remains 0.
- Store:
  - Stimulus: req1=1, we1=1, addr1=0x2000, wdata1=0xA5.
  - Required: mem_memwrite 1 cycle with mem_addr=0x2000 and mem_wdata=0xA5; done1; no change to rdata1.
- Simultaneous requests:
  - Stimulus: from reset, req0 and req1 held high for 3 accesses.
  - Required: grant order 0,1,0. With DMEM_ARB_FIXED_PRIO_EN defined, the order is 0,0,0.
- Stall:
  - Stimulus: mem_stall=1 for 4 cycles during WAIT.
  - Required: done is delayed exactly 4 cycles; mem_addr is stable throughout; no second gnt.
- Reset mid-operation:
  - Stimulus: assert reset in WAIT.
  - Required: all outputs 0 immediately (async); after release, the next simultaneous request grants port 0.
- Early drop:
  - Stimulus: req1 pulsed for 1 cycle while port 0 is in WAIT.
  - Required: gnt1 never asserts; FSM returns to IDLE after done0.
